// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port SRAM (combinational read, posedge write) between two
//   requesters: req0 (DLX core data port) and req1 (TinyML accelerator / DMA).
//   At most one access is granted per cycle. Read data comes back registered, one
//   cycle after the grant. An owner's run is capped at MAX_BURST grants while the
//   other side is waiting, so neither side starves.
//
// Optional feature macro: SRAM_ARB_RR_EN
//   defined   : an IDLE tie goes to the side that did not win last (round-robin)
//   undefined : an IDLE tie always goes to req0 (fixed priority)
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_reqN/i_weN/i_addrN/i_wdataN   requester N access (held until o_gntN)
//   o_gntN                    access performed this cycle (combinational)
//   o_rvalidN/o_rdataN        registered read return, one cycle after a read grant
//   o_sram_addr/write/wdata   SRAM drive
//   i_sram_rdata              SRAM combinational read data
//   o_owner                   FSM state: 0=IDLE, 1=OWN0, 2=OWN1
module sram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req0,
  input  logic                  i_we0,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [31:0]           i_wdata0,
  output logic                  o_gnt0,
  output logic                  o_rvalid0,
  output logic [31:0]           o_rdata0,
  input  logic                  i_req1,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [31:0]           i_wdata1,
  output logic                  o_gnt1,
  output logic                  o_rvalid1,
  output logic [31:0]           o_rdata1,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_sram_write,
  output logic [31:0]           o_sram_wdata,
  input  logic [31:0]           i_sram_rdata,
  output logic [1:0]            o_owner
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } state_e;

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic                    tie_to1;

`ifdef SRAM_ARB_RR_EN
  logic last_q;  // 1: req1 won the most recent grant

  assign tie_to1 = ~last_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last_q <= 1'b1;
    end else if (o_gnt0 || o_gnt1) begin
      last_q <= o_gnt1;
    end
  end
`else
  assign tie_to1 = 1'b0;
`endif

  // Grant decision; forced off while in reset so no write can slip through.
  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (!i_reset) begin
      case (state_q)
        StOwn0: begin
          if (i_req0) begin
            if (i_req1 && (cnt_q >= MaxCnt)) o_gnt1 = 1'b1;
            else                             o_gnt0 = 1'b1;
          end else begin
            o_gnt1 = i_req1;
          end
        end
        StOwn1: begin
          if (i_req1) begin
            if (i_req0 && (cnt_q >= MaxCnt)) o_gnt0 = 1'b1;
            else                             o_gnt1 = 1'b1;
          end else begin
            o_gnt0 = i_req0;
          end
        end
        default: begin
          if (i_req0 && i_req1) begin
            o_gnt1 = tie_to1;
            o_gnt0 = ~tie_to1;
          end else begin
            o_gnt0 = i_req0;
            o_gnt1 = i_req1;
          end
        end
      endcase
    end
  end

  always_comb begin
    state_d = StIdle;
    cnt_d   = '0;
    if (o_gnt0) begin
      state_d = StOwn0;
      if (state_q == StOwn0) cnt_d = (cnt_q == MaxCnt) ? cnt_q : cnt_q + CntW'(1);
      else                   cnt_d = CntW'(1);
    end else if (o_gnt1) begin
      state_d = StOwn1;
      if (state_q == StOwn1) cnt_d = (cnt_q == MaxCnt) ? cnt_q : cnt_q + CntW'(1);
      else                   cnt_d = CntW'(1);
    end
  end

  // SRAM drive: granted side, otherwise hold the last granted address/data.
  always_comb begin
    o_sram_addr  = addr_q;
    o_sram_wdata = wdata_q;
    if (o_gnt1) begin
      o_sram_addr  = i_addr1;
      o_sram_wdata = i_wdata1;
    end else if (o_gnt0) begin
      o_sram_addr  = i_addr0;
      o_sram_wdata = i_wdata0;
    end
  end

  assign o_sram_write = (o_gnt0 & i_we0) | (o_gnt1 & i_we1);
  assign o_owner      = state_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      o_rvalid0 <= 1'b0;
      o_rvalid1 <= 1'b0;
      o_rdata0  <= '0;
      o_rdata1  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      o_rvalid0 <= o_gnt0 & ~i_we0;
      o_rvalid1 <= o_gnt1 & ~i_we1;
      if (o_gnt0 || o_gnt1) begin
        addr_q  <= o_sram_addr;
        wdata_q <= o_sram_wdata;
      end
      if (o_gnt0 && !i_we0) o_rdata0 <= i_sram_rdata;
      if (o_gnt1 && !i_we1) o_rdata1 <= i_sram_rdata;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: an SRAM model sits on the SRAM port, and a
// transaction-level reference (owner, run length, expected memory image) predicts
// every cycle's grants, SRAM drive and read returns.
module tb_sram_port_arbiter;
  localparam int AW = 8;
  localparam int MB = 4;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_req0, i_we0, i_req1, i_we1;
  logic [AW-1:0] i_addr0, i_addr1;
  logic [31:0]   i_wdata0, i_wdata1;
  logic          o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_sram_write;
  logic [31:0]   o_rdata0, o_rdata1, o_sram_wdata, i_sram_rdata;
  logic [AW-1:0] o_sram_addr;
  logic [1:0]    o_owner;

  always #5 i_clk = ~i_clk;

  sram_port_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req0(i_req0), .i_we0(i_we0), .i_addr0(i_addr0), .i_wdata0(i_wdata0),
    .o_gnt0(o_gnt0), .o_rvalid0(o_rvalid0), .o_rdata0(o_rdata0),
    .i_req1(i_req1), .i_we1(i_we1), .i_addr1(i_addr1), .i_wdata1(i_wdata1),
    .o_gnt1(o_gnt1), .o_rvalid1(o_rvalid1), .o_rdata1(o_rdata1),
    .o_sram_addr(o_sram_addr), .o_sram_write(o_sram_write),
    .o_sram_wdata(o_sram_wdata), .i_sram_rdata(i_sram_rdata), .o_owner(o_owner)
  );

  // SRAM on the shared port
  logic [31:0] sram_mem [256];
  assign i_sram_rdata = sram_mem[o_sram_addr];
  always @(posedge i_clk) if (o_sram_write) sram_mem[o_sram_addr] <= o_sram_wdata;

  // Reference model state
  int          m_owner = 0;  // 0 idle, 1 req0 owns, 2 req1 owns
  int          m_run   = 0;  // consecutive grants to the current owner
  int          m_last  = 1;  // most recent winner
  logic        m_rv [2];
  logic [31:0] m_rd [2];
  logic [31:0] ref_mem [256];
  logic [7:0]  m_alast = '0;
  bit          m_avalid = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  function automatic int pick();
    if (i_reset || (!i_req0 && !i_req1)) return -1;
    if (i_req0 != i_req1) return i_req0 ? 0 : 1;
    if (m_owner != 0) return (m_run < MB) ? (m_owner - 1) : (2 - m_owner);
`ifdef SRAM_ARB_RR_EN
    return 1 - m_last;
`else
    return 0;
`endif
  endfunction

  task automatic sel(input int w, output logic we, output logic [7:0] a, output logic [31:0] d);
    if (w == 1) begin we = i_we1; a = i_addr1; d = i_wdata1; end
    else        begin we = i_we0; a = i_addr0; d = i_wdata0; end
  endtask

  task automatic predict(output logic [110:0] e, output logic [110:0] m);
    int w; logic we; logic [7:0] a; logic [31:0] d;
    w = pick();
    sel(w, we, a, d);
    e = {(w == 0), (w == 1), ((w >= 0) && we), 2'(m_owner), m_rv[0], m_rv[1], m_rd[0], m_rd[1],
         ((w >= 0) ? a : m_alast), d};
    m = {{71{1'b1}}, {8{(w >= 0) || m_avalid}}, {32{(w >= 0) && we}}};
  endtask

  function automatic logic [110:0] observe();
    return {o_gnt0, o_gnt1, o_sram_write, o_owner, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
            o_sram_addr, o_sram_wdata};
  endfunction

  // Clock edge plus reference update from the pre-edge inputs.
  task automatic advance();
    int w; logic we; logic [7:0] a; logic [31:0] d; logic rst;
    w = pick();
    sel(w, we, a, d);
    rst = i_reset;
    @(posedge i_clk);
    m_rv[0] = 1'b0;
    m_rv[1] = 1'b0;
    if (rst) begin
      m_owner = 0; m_run = 0; m_last = 1; m_avalid = 1'b0;
      m_rd[0] = '0; m_rd[1] = '0;
    end else if (w < 0) begin
      m_owner = 0; m_run = 0;
    end else begin
      if (m_owner == w + 1) m_run++;
      else begin m_owner = w + 1; m_run = 1; end
      m_last = w; m_alast = a; m_avalid = 1'b1;
      if (we) ref_mem[a] = d;
      else begin m_rv[w] = 1'b1; m_rd[w] = ref_mem[a]; end
    end
    #1;
  endtask

  task automatic drive(input logic rst, input logic r0, input logic w0, input logic [7:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1,
                       input logic [7:0] a1, input logic [31:0] d1);
    i_reset = rst;
    i_req0 = r0; i_we0 = w0; i_addr0 = a0; i_wdata0 = d0;
    i_req1 = r1; i_we1 = w1; i_addr1 = a1; i_wdata1 = d1;
  endtask

  task automatic test_reset();
    logic [110:0] e, m;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 8'(i), $urandom, 1, 1, 8'(i + 1), $urandom);
      @(negedge i_clk);
      predict(e, m);
      n_vec++;
      if ((observe() & m) !== (e & m)) begin
        n_err++;
        $display("FAIL reset cyc%0d: got %h want %h", i, observe() & m, e & m);
      end
      advance();
    end
  endtask

  task automatic load_memory();
    logic [110:0] e, m;
    for (int i = 0; i < 256; i++) begin
      drive(0, 1, 1, 8'(i), $urandom, 0, 0, 0, 0);
      @(negedge i_clk);
      predict(e, m);
      n_vec++;
      if ((observe() & m) !== (e & m)) begin
        n_err++;
        $display("FAIL load a%0d: got %h want %h", i, observe() & m, e & m);
      end
      advance();
    end
  endtask

  task automatic test_write_read();
    logic [110:0] e, m;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(0, 1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        1:       drive(0, 1, 0, 8'h10, 32'h0, 0, 0, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      @(negedge i_clk);
      predict(e, m);
      n_vec++;
      if ((observe() & m) !== (e & m)) begin
        n_err++;
        $display("FAIL write_read cyc%0d: got %h want %h", i, observe() & m, e & m);
      end
      if (i == 2) begin
        n_vec++;
        if ({o_rvalid0, o_rdata0} !== {1'b1, 32'hDEADBEEF}) begin
          n_err++;
          $display("FAIL write_read data: got %b/%h want 1/deadbeef", o_rvalid0, o_rdata0);
        end
      end
      advance();
    end
  endtask

  task automatic test_contention();
    logic [110:0] e, m;
    int order [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    int won;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, $urandom_range(0, 1), 8'($urandom), $urandom,
               1, $urandom_range(0, 1), 8'($urandom), $urandom);
      @(negedge i_clk);
      predict(e, m);
      n_vec++;
      if ((observe() & m) !== (e & m)) begin
        n_err++;
        $display("FAIL contention cyc%0d: got %h want %h", i, observe() & m, e & m);
      end
      won = (o_gnt0 && !o_gnt1) ? 0 : (o_gnt1 && !o_gnt0) ? 1 : -1;
      if (i < 9) begin
        n_vec++;
        if (won != order[i]) begin
          n_err++;
          $display("FAIL contention order cyc%0d: got %0d want %0d", i, won, order[i]);
        end
      end
      advance();
    end
  endtask

  task automatic test_tie();
    logic [110:0] e, m;
    int won;
    int want;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive(0, 1, 0, 8'($urandom), 0, 1, 0, 8'($urandom), 0);
      else            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge i_clk);
      predict(e, m);
      n_vec++;
      if ((observe() & m) !== (e & m)) begin
        n_err++;
        $display("FAIL tie cyc%0d: got %h want %h", i, observe() & m, e & m);
      end
      if (i % 2 == 0) begin
`ifdef SRAM_ARB_RR_EN
        want = (i / 2) % 2;
`else
        want = 0;
`endif
        won = o_gnt1 ? 1 : 0;
        n_vec++;
        if (won != want || (o_gnt0 == o_gnt1)) begin
          n_err++;
          $display("FAIL tie winner %0d: got g0=%b g1=%b want req%0d", i / 2, o_gnt0, o_gnt1, want);
        end
      end
      advance();
    end
  endtask

  task automatic test_raw();
    logic [110:0] e, m;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(0, 0, 0, 0, 0, 1, 1, 8'hFF, 32'h55);
        1:       drive(0, 0, 0, 0, 0, 1, 0, 8'hFF, 32'h0);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      @(negedge i_clk);
      predict(e, m);
      n_vec++;
      if ((observe() & m) !== (e & m)) begin
        n_err++;
        $display("FAIL raw cyc%0d: got %h want %h", i, observe() & m, e & m);
      end
      if (i == 2) begin
        n_vec++;
        if ({o_rvalid1, o_rdata1} !== {1'b1, 32'h00000055}) begin
          n_err++;
          $display("FAIL raw data: got %b/%h want 1/00000055", o_rvalid1, o_rdata1);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_read();
    logic [110:0] e, m;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(0, 1, 0, 8'h20, 0, 0, 0, 0, 0);
        1:       drive(1, 1, 0, 8'h21, 0, 1, 1, 8'h22, 32'hCAFEF00D);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      @(negedge i_clk);
      predict(e, m);
      n_vec++;
      if ((observe() & m) !== (e & m)) begin
        n_err++;
        $display("FAIL reset_mid cyc%0d: got %h want %h", i, observe() & m, e & m);
      end
      if (i == 1) begin
        n_vec++;
        if ({o_gnt0, o_gnt1, o_sram_write} !== 3'b000) begin
          n_err++;
          $display("FAIL reset_mid gate: got %b%b%b want 000", o_gnt0, o_gnt1, o_sram_write);
        end
      end
      if (i == 2) begin
        n_vec++;
        if ({o_rvalid0, o_owner} !== 3'b000) begin
          n_err++;
          $display("FAIL reset_mid after: got rvalid0=%b owner=%0d want 0/0", o_rvalid0, o_owner);
        end
      end
      advance();
    end
  endtask

  task automatic test_lone();
    logic [110:0] e, m;
    int grants = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0, 8'($urandom), 0);
      @(negedge i_clk);
      predict(e, m);
      n_vec++;
      if ((observe() & m) !== (e & m)) begin
        n_err++;
        $display("FAIL lone cyc%0d: got %h want %h", i, observe() & m, e & m);
      end
      if (o_gnt1) grants++;
      advance();
    end
    n_vec++;
    if (grants != 20) begin
      n_err++;
      $display("FAIL lone count: got %0d want 20", grants);
    end
  endtask

  task automatic test_random();
    logic [110:0] e, m;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0),
            ($urandom_range(0, 9) < 7), $urandom_range(0, 1), 8'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 9) < 6), $urandom_range(0, 1), 8'($urandom_range(0, 7)), $urandom);
      @(negedge i_clk);
      predict(e, m);
      n_vec++;
      if ((observe() & m) !== (e & m)) begin
        n_err++;
        $display("FAIL random cyc%0d: got %h want %h", i, observe() & m, e & m);
      end
      advance();
    end
  endtask

  initial begin
    m_rv[0] = 1'b0; m_rv[1] = 1'b0;
    m_rd[0] = '0;   m_rd[1] = '0;
    test_reset();
    load_memory();
    test_write_read();
    test_contention();
    test_tie();
    test_raw();
    test_reset_mid_read();
    test_lone();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
